redirect_ctrl: RTL and testbench
================================

Name: redirect_ctrl

Overview:
- Sequences control-flow redirects for the pipelined WiscSP13 core.
- Takes branch/jump resolution from the execute stage and selects the redirect target.
- Holds the redirect while instruction memory is stalled, then drives PC load and IF/ID, ID/EX squash for a programmable drain window.
- Also owns the sticky halt state and a saturating redirect counter for performance debug.

Parameters:
- FLUSH_CYCLES, 2, squash cycles after the redirect is issued (0 allowed; max 15).

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- ex_valid  input  1  execute stage holds a valid, non-squashed instruction
- is_branch  input  1  instruction is a conditional branch
- br_taken  input  1  branch condition true (ignored unless is_branch)
- J_JAL  input  1  instruction is J or JAL
- JR_JALR  input  1  instruction is JR or JALR
- halt  input  1  instruction is HALT
- branch_PC  input  16  conditional-branch target
- J_JAL_addr  input  16  J/JAL target
- EX_out  input  16  ALU result, used as JR/JALR target
- imem_stall  input  1  instruction memory cannot accept a new fetch address
- redirect  output  1  load redirect_PC into PC this cycle
- redirect_PC  output  16  registered redirect target
- flush_IF_ID  output  1  squash IF/ID register
- flush_ID_EX  output  1  squash ID/EX register
- pc_hold  output  1  freeze PC register
- halted  output  1  core halted
- redirect_cnt  output  16  number of redirects issued, saturating

Behaviour:
- Reset:
  - State IDLE; tgt_q, cnt and redirect_cnt = 0.
  - All 1-bit outputs 0; redirect_PC = 0.
  - Reset mid-operation discards any pending redirect and clears HALTED.
- Target selection (combinational, 16-bit pass-through, no alignment):
  - Priority JR_JALR (EX_out) > J_JAL (J_JAL_addr) > is_branch & br_taken (branch_PC).
  - take = ex_valid & (JR_JALR | J_JAL | (is_branch & br_taken)).
- States: IDLE, PENDING, FLUSH, HALTED. redirect_PC = tgt_q at all times.
- IDLE:
  - All outputs 0.
  - ex_valid & halt -> HALTED; halt wins over take in the same cycle.
  - Otherwise take -> latch target into tgt_q, go to PENDING.
  - Otherwise stay in IDLE.
- PENDING:
  - flush_IF_ID = flush_ID_EX = 1.
  - pc_hold = imem_stall.
  - redirect = !imem_stall.
  - Edge with imem_stall=0: redirect_cnt += 1 (saturates at 0xFFFF). If FLUSH_CYCLES=0 go to IDLE; else load cnt = FLUSH_CYCLES-1 and go to FLUSH.
  - Edge with imem_stall=1: stay in PENDING, tgt_q unchanged.
- FLUSH:
  - flush_IF_ID = flush_ID_EX = 1; redirect = 0; pc_hold = 0.
  - cnt==0 -> IDLE; else cnt -= 1.
- Inputs in PENDING/FLUSH:
  - ex_valid, take and halt are ignored; those instructions are wrong-path.
  - No second redirect may queue.
- HALTED:
  - halted = pc_hold = 1; all other 1-bit outputs 0.
  - Exited only by rst.
- Latency:
  - Resolution sampled at end of cycle N -> redirect asserted in cycle N+1 at the earliest.
  - imem_stall delays the redirect by exactly the number of stalled cycles.
  - Total squash window = (PENDING cycles) + FLUSH_CYCLES.
- redirect_cnt is never cleared except by rst.

Test Plan:
- Taken branch, imem_stall=0, branch_PC=0x0040: redirect=1 with redirect_PC=0x0040 in cycle N+1. Flush outputs high in cycles N+1..N+3 (FLUSH_CYCLES=2), low in N+4. redirect_cnt=1.
- Same cycle JR_JALR=1, J_JAL=1, is_branch=br_taken=1, EX_out=0x1234, J_JAL_addr=0x2000, branch_PC=0x3000: redirect_PC=0x1234. Next case, is_branch=1, br_taken=0: no redirect, outputs stay 0.
- J_JAL to 0x0100 with imem_stall high for 3 cycles after resolution: pc_hold=1 and redirect=0 for 3 cycles; redirect=1 on the 4th; redirect_PC stays 0x0100; a spurious take with ex_valid=1 during the stall has no effect.
- ex_valid & halt & J_JAL in the same cycle: HALTED entered, halted=pc_hold=1, no redirect, redirect_cnt unchanged. Later take inputs ignored until rst; rst returns to IDLE with all outputs 0.
- Assert rst while in PENDING with imem_stall=1: next cycle IDLE, redirect never issued, redirect_cnt=0. Build with FLUSH_CYCLES=0: taken branch gives a single redirect cycle, then IDLE.
- Preload 0xFFFE redirects via a fast loop (or force): two more redirects leave redirect_cnt=0xFFFF with no wrap.

Source files
------------

// File: rtl/redirect_ctrl.sv
// Control-flow redirect sequencer for the pipelined WiscSP13 core: selects the
// branch/jump target, waits out imem stalls, squashes wrong-path stages, owns halt.
module redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        is_branch,
    input  logic        br_taken,
    input  logic        J_JAL,
    input  logic        JR_JALR,
    input  logic        halt,
    input  logic [15:0] branch_PC,
    input  logic [15:0] J_JAL_addr,
    input  logic [15:0] EX_out,
    input  logic        imem_stall,
    output logic        redirect,
    output logic [15:0] redirect_PC,
    output logic        flush_IF_ID,
    output logic        flush_ID_EX,
    output logic        pc_hold,
    output logic        halted,
    output logic [15:0] redirect_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_FLUSH,
        S_HALTED
    } state_t;

    localparam logic [3:0] CNT_LOAD = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_tgt_q;
    logic [3:0]  r_cnt;
    logic [15:0] r_redirect_cnt;

    logic        w_take;
    logic [15:0] w_tgt;

    assign w_take = ex_valid & (JR_JALR | J_JAL | (is_branch & br_taken));

    always_comb begin
        if (JR_JALR)    w_tgt = EX_out;
        else if (J_JAL) w_tgt = J_JAL_addr;
        else            w_tgt = branch_PC;
    end

    // NOTE: state is updated with non-blocking assignments so every branch of the
    // case reads the pre-edge values of r_state/r_cnt, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_tgt_q        <= 16'h0000;
            r_cnt          <= 4'd0;
            r_redirect_cnt <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ex_valid && halt) begin
                        r_state <= S_HALTED;
                    end else if (w_take) begin
                        r_tgt_q <= w_tgt;
                        r_state <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (!imem_stall) begin
                        if (r_redirect_cnt != 16'hFFFF)
                            r_redirect_cnt <= r_redirect_cnt + 16'd1;
                        r_cnt   <= CNT_LOAD;
                        r_state <= (FLUSH_CYCLES == 0) ? S_IDLE : S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == 4'd0) r_state <= S_IDLE;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch;
    // redirect/pc_hold must track imem_stall within the cycle, hence decoded here.
    always_comb begin
        redirect    = 1'b0;
        flush_IF_ID = 1'b0;
        flush_ID_EX = 1'b0;
        pc_hold     = 1'b0;
        halted      = 1'b0;
        case (r_state)
            S_PENDING: begin
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
                pc_hold     = imem_stall;
                redirect    = !imem_stall;
            end
            S_FLUSH: begin
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
            end
            S_HALTED: begin
                halted  = 1'b1;
                pc_hold = 1'b1;
            end
            default: ;
        endcase
    end

    assign redirect_PC  = r_tgt_q;
    assign redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Self-checking bench for redirect_ctrl: scoreboard of expected redirect targets plus
// per-cycle output checks on a FLUSH_CYCLES=2 and a FLUSH_CYCLES=0 instance.
module tb_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, is_branch, br_taken, J_JAL, JR_JALR, halt, imem_stall;
    logic [15:0] branch_PC, J_JAL_addr, EX_out;

    logic        a_redirect, a_flush_IF_ID, a_flush_ID_EX, a_pc_hold, a_halted;
    logic [15:0] a_redirect_PC, a_redirect_cnt;
    logic        b_redirect, b_flush_IF_ID, b_flush_ID_EX, b_pc_hold, b_halted;
    logic [15:0] b_redirect_PC, b_redirect_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    redirect_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .is_branch(is_branch),
        .br_taken(br_taken), .J_JAL(J_JAL), .JR_JALR(JR_JALR), .halt(halt),
        .branch_PC(branch_PC), .J_JAL_addr(J_JAL_addr), .EX_out(EX_out),
        .imem_stall(imem_stall), .redirect(a_redirect), .redirect_PC(a_redirect_PC),
        .flush_IF_ID(a_flush_IF_ID), .flush_ID_EX(a_flush_ID_EX), .pc_hold(a_pc_hold),
        .halted(a_halted), .redirect_cnt(a_redirect_cnt)
    );

    redirect_ctrl #(.FLUSH_CYCLES(0)) dut_fc0 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .is_branch(is_branch),
        .br_taken(br_taken), .J_JAL(J_JAL), .JR_JALR(JR_JALR), .halt(halt),
        .branch_PC(branch_PC), .J_JAL_addr(J_JAL_addr), .EX_out(EX_out),
        .imem_stall(imem_stall), .redirect(b_redirect), .redirect_PC(b_redirect_PC),
        .flush_IF_ID(b_flush_IF_ID), .flush_ID_EX(b_flush_ID_EX), .pc_hold(b_pc_hold),
        .halted(b_halted), .redirect_cnt(b_redirect_cnt)
    );

    // Packed as {redirect, flush_IF_ID, flush_ID_EX, pc_hold, halted}.
    function automatic logic [4:0] outs_a();
        return {a_redirect, a_flush_IF_ID, a_flush_ID_EX, a_pc_hold, a_halted};
    endfunction

    function automatic logic [4:0] outs_b();
        return {b_redirect, b_flush_IF_ID, b_flush_ID_EX, b_pc_hold, b_halted};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        ex_valid = 0; is_branch = 0; br_taken = 0; J_JAL = 0; JR_JALR = 0; halt = 0;
        imem_stall = 0; branch_PC = '0; J_JAL_addr = '0; EX_out = '0;
    endtask

    // Mid-cycle sample; any redirect must match the oldest queued target.
    task automatic sample();
        @(negedge clk);
        if (a_redirect) begin
            if (exp_q.size() == 0) check("spurious_redirect", {31'd0, a_redirect}, 32'd0);
            else                   check("redirect_pc", {16'd0, a_redirect_PC}, {16'd0, exp_q.pop_front()});
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Four cycles following a resolution with no stall, on the FLUSH_CYCLES=2 instance.
    task automatic drain(input string tag, input logic [15:0] exp_cnt);
        clear_inputs();
        sample(); check({tag, "_n1"}, {27'd0, outs_a()}, 32'b11100); adv();
        sample(); check({tag, "_n2"}, {27'd0, outs_a()}, 32'b01100); adv();
        sample(); check({tag, "_n3"}, {27'd0, outs_a()}, 32'b01100); adv();
        sample(); check({tag, "_n4"}, {27'd0, outs_a()}, 32'b00000);
        check({tag, "_cnt"}, {16'd0, a_redirect_cnt}, {16'd0, exp_cnt}); adv();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        adv(); adv();
        sample();
        check("reset_outs", {27'd0, outs_a()}, 32'd0);
        check("reset_pc", {16'd0, a_redirect_PC}, 32'd0);
        check("reset_cnt", {16'd0, a_redirect_cnt}, 32'd0);
        rst = 0;
        adv();

        // Taken branch to 0x0040; FLUSH_CYCLES=0 instance checked alongside.
        ex_valid = 1; is_branch = 1; br_taken = 1; branch_PC = 16'h0040;
        exp_q.push_back(16'h0040);
        sample(); check("br_idle", {27'd0, outs_a()}, 32'd0); adv();
        clear_inputs();
        sample();
        check("br_n1", {27'd0, outs_a()}, 32'b11100);
        check("fc0_n1", {27'd0, outs_b()}, 32'b11100);
        check("fc0_pc", {16'd0, b_redirect_PC}, 32'h0040);
        adv();
        sample();
        check("br_n2", {27'd0, outs_a()}, 32'b01100);
        check("fc0_n2", {27'd0, outs_b()}, 32'b00000);
        adv();
        sample(); check("br_n3", {27'd0, outs_a()}, 32'b01100); adv();
        sample();
        check("br_n4", {27'd0, outs_a()}, 32'b00000);
        check("br_cnt", {16'd0, a_redirect_cnt}, 32'd1);
        check("fc0_cnt", {16'd0, b_redirect_cnt}, 32'd1);
        adv();

        // All redirect sources at once: JR/JALR wins.
        ex_valid = 1; JR_JALR = 1; J_JAL = 1; is_branch = 1; br_taken = 1;
        EX_out = 16'h1234; J_JAL_addr = 16'h2000; branch_PC = 16'h3000;
        exp_q.push_back(16'h1234);
        sample(); adv();
        drain("prio", 16'd2);

        // Not-taken branch: nothing happens.
        ex_valid = 1; is_branch = 1; br_taken = 0; branch_PC = 16'h0500;
        for (int i = 0; i < 3; i++) begin
            sample(); check("not_taken", {27'd0, outs_a()}, 32'd0); adv();
        end

        // J/JAL to 0x0100 with three stalled cycles and a wrong-path take mid-stall.
        clear_inputs();
        ex_valid = 1; J_JAL = 1; J_JAL_addr = 16'h0100;
        exp_q.push_back(16'h0100);
        sample(); adv();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            imem_stall = 1;
            if (i == 1) begin
                ex_valid = 1; JR_JALR = 1; EX_out = 16'hBEEF;
            end
            sample();
            check("stall_outs", {27'd0, outs_a()}, 32'b01110);
            check("stall_pc", {16'd0, a_redirect_PC}, 32'h0100);
            adv();
        end
        drain("stall", 16'd3);

        // Reset while PENDING and stalled: redirect is discarded.
        ex_valid = 1; J_JAL = 1; J_JAL_addr = 16'h0200;
        sample(); adv();
        clear_inputs();
        imem_stall = 1; rst = 1;
        sample(); check("rstp_pend", {27'd0, outs_a()}, 32'b01110); adv();
        rst = 0; imem_stall = 0;
        sample();
        check("rstp_outs", {27'd0, outs_a()}, 32'd0);
        check("rstp_cnt", {16'd0, a_redirect_cnt}, 32'd0);
        check("rstp_pc", {16'd0, a_redirect_PC}, 32'd0);
        adv();
        sample(); check("rstp_idle", {27'd0, outs_a()}, 32'd0); adv();

        // Halt beats a simultaneous jump; later takes are ignored until reset.
        ex_valid = 1; halt = 1; J_JAL = 1; J_JAL_addr = 16'h0300;
        sample(); adv();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            ex_valid = 1; is_branch = 1; br_taken = 1; J_JAL = (i == 1); branch_PC = 16'h0400;
            sample();
            check("halt_outs", {27'd0, outs_a()}, 32'b00011);
            check("halt_cnt", {16'd0, a_redirect_cnt}, 32'd0);
            adv();
        end
        clear_inputs();
        rst = 1; adv();
        rst = 0;
        sample(); check("halt_rst", {27'd0, outs_a()}, 32'd0); adv();

        // Saturation: preload 0xFFFE, then two redirects.
        force dut.r_redirect_cnt = 16'hFFFE;
        adv();
        release dut.r_redirect_cnt;
        sample(); check("sat_preload", {16'd0, a_redirect_cnt}, 32'h0000FFFE); adv();
        ex_valid = 1; is_branch = 1; br_taken = 1; branch_PC = 16'h0ABC;
        exp_q.push_back(16'h0ABC);
        sample(); adv();
        drain("sat1", 16'hFFFF);
        ex_valid = 1; J_JAL = 1; J_JAL_addr = 16'h0DEF;
        exp_q.push_back(16'h0DEF);
        sample(); adv();
        drain("sat2", 16'hFFFF);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
